// File: rtl/gfx_bus_pkg.sv
// gfx_bus_pkg: shared types and register indices for the graphics register bus master
package gfx_bus_pkg;
  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;
  typedef struct packed {
    logic       write;
    logic [3:0] addr;
    logic [7:0] wdata;
  } req_t;
  localparam logic [3:0] REG_MODE     = 4'd0;
  localparam logic [3:0] REG_DATA     = 4'd1;
  localparam logic [3:0] REG_WADDR_LO = 4'd3;
  localparam logic [3:0] REG_WADDR_HI = 4'd4;
endpackage

// File: rtl/gfx_bus_req_fifo.sv
// gfx_bus_req_fifo: show-ahead request FIFO, flushed by reset
module gfx_bus_req_fifo import gfx_bus_pkg::*; #(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic pop,
  input  req_t din,
  output req_t dout,
  output logic full,
  output logic empty
);
  localparam int AW = $clog2(DEPTH);
  req_t mem_q [DEPTH];
  logic [AW:0] wr_q, wr_d, rd_q, rd_d;
  assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign empty = wr_q == rd_q;
  assign dout  = mem_q[rd_q[AW-1:0]];
  // advance pointers on accepted push/pop
  always_comb begin
    wr_d = wr_q + (AW+1)'(push && !full);
    rd_d = rd_q + (AW+1)'(pop && !empty);
  end
  // pointer registers, cleared (flushed) by reset
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  // storage needs no reset; pointers define validity
  always_ff @(posedge clk)
    if (push && !full) mem_q[wr_q[AW-1:0]] <= din;
endmodule

// File: rtl/gfx_bus_master.sv
// gfx_bus_master: replays queued register requests as cs/rs/wren bus cycles
module gfx_bus_master import gfx_bus_pkg::*; #(
  parameter int SETUP_CYC  = 1,
  parameter int STROBE_CYC = 4,
  parameter int HOLD_CYC   = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_write,
  input  logic [3:0] req_reg,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       busy,
  output logic       bus_cs_n,
  output logic [3:0] bus_rs,
  output logic       bus_wren_n,
  output logic [7:0] bus_data_o,
  output logic       bus_data_oe,
  input  logic [7:0] bus_data_i
);
  localparam int CW = 8;
  req_t head, req_in;
  logic full, empty, pop;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic avail_q, avail_d, wr_q, wr_d;
  logic cs_n_q, cs_n_d, wren_n_q, wren_n_d, oe_q, oe_d, rsp_valid_q, rsp_valid_d;
  logic [3:0] rs_q, rs_d;
  logic [7:0] data_o_q, data_o_d, rdata_q, rdata_d;
  assign req_in      = {req_write, req_reg, req_wdata};
  assign req_ready   = !full;
  assign busy        = !empty || state_q != IDLE;
  assign bus_cs_n    = cs_n_q;
  assign bus_wren_n  = wren_n_q;
  assign bus_rs      = rs_q;
  assign bus_data_o  = data_o_q;
  assign bus_data_oe = oe_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rdata_q;
  gfx_bus_req_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .push(req_valid && req_ready), .pop(pop),
    .din(req_in), .dout(head), .full(full), .empty(empty)
  );
  // phase sequencing; a fresh entry is issued one cycle after it becomes visible (avail_q)
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q - CW'(1);
    avail_d     = !empty;
    wr_d        = wr_q;
    cs_n_d      = cs_n_q;
    wren_n_d    = wren_n_q;
    oe_d        = oe_q;
    rs_d        = rs_q;
    data_o_d    = data_o_q;
    rdata_d     = rdata_q;
    rsp_valid_d = 1'b0;
    pop         = 1'b0;
    case (state_q)
      IDLE: if (avail_q && !empty) begin
        pop      = 1'b1;
        state_d  = SETUP;
        cnt_d    = CW'(SETUP_CYC - 1);
        wr_d     = head.write;
        rs_d     = head.addr;
        oe_d     = head.write;
        data_o_d = head.wdata;
      end
      SETUP: if (cnt_q == '0) begin
        state_d  = STROBE;
        cnt_d    = CW'(STROBE_CYC - 1);
        cs_n_d   = 1'b0;
        wren_n_d = !wr_q;
      end
      STROBE: if (cnt_q == '0) begin
        state_d     = HOLD;
        cnt_d       = CW'(HOLD_CYC - 1);
        cs_n_d      = 1'b1;
        wren_n_d    = 1'b1;
        rsp_valid_d = !wr_q;
        rdata_d     = wr_q ? rdata_q : bus_data_i;
      end
      HOLD: if (cnt_q == '0) begin
        state_d = IDLE;
        oe_d    = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end
  // FSM state and registered bus outputs; reset releases the bus at once
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      avail_q     <= 1'b0;
      wr_q        <= 1'b0;
      cs_n_q      <= 1'b1;
      wren_n_q    <= 1'b1;
      oe_q        <= 1'b0;
      rs_q        <= '0;
      data_o_q    <= '0;
      rdata_q     <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      avail_q     <= avail_d;
      wr_q        <= wr_d;
      cs_n_q      <= cs_n_d;
      wren_n_q    <= wren_n_d;
      oe_q        <= oe_d;
      rs_q        <= rs_d;
      data_o_q    <= data_o_d;
      rdata_q     <= rdata_d;
      rsp_valid_q <= rsp_valid_d;
    end
endmodule

// File: tb/tb_gfx_bus_master.sv
// tb_gfx_bus_master: vector table, bus monitor with request queue model, random soak
module tb_gfx_bus_master;
  import gfx_bus_pkg::*;
  localparam int S = 1, T = 4, H = 1, D = 4, GAP = H + 1 + S, NR = 40;
  logic clk = 0, rst = 1;
  logic req_valid = 0, req_write = 0, req_ready, rsp_valid, busy, bus_cs_n, bus_wren_n, bus_data_oe;
  logic [3:0] req_reg = 0, bus_rs;
  logic [7:0] req_wdata = 0, rsp_rdata, bus_data_o, bus_data_i = 0;
  logic b_req_valid = 0, b_req_write = 0, b_req_ready, b_rsp_valid, b_busy, b_cs_n, b_wren_n, b_oe;
  logic [3:0] b_req_reg = 0, b_rs;
  logic [7:0] b_req_wdata = 0, b_rdata, b_data_o, b_data_i = 0;
  always #5 clk = ~clk;

  gfx_bus_master #(.SETUP_CYC(S), .STROBE_CYC(T), .HOLD_CYC(H), .FIFO_DEPTH(D)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_reg(req_reg), .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .busy(busy), .bus_cs_n(bus_cs_n), .bus_rs(bus_rs), .bus_wren_n(bus_wren_n),
    .bus_data_o(bus_data_o), .bus_data_oe(bus_data_oe), .bus_data_i(bus_data_i));

  gfx_bus_master #(.SETUP_CYC(1), .STROBE_CYC(1), .HOLD_CYC(1), .FIFO_DEPTH(D)) dut_b (
    .clk(clk), .rst(rst), .req_valid(b_req_valid), .req_ready(b_req_ready), .req_write(b_req_write),
    .req_reg(b_req_reg), .req_wdata(b_req_wdata), .rsp_valid(b_rsp_valid), .rsp_rdata(b_rdata),
    .busy(b_busy), .bus_cs_n(b_cs_n), .bus_rs(b_rs), .bus_wren_n(b_wren_n),
    .bus_data_o(b_data_o), .bus_data_oe(b_oe), .bus_data_i(b_data_i));

  typedef struct packed {logic w; logic [3:0] r; logic [7:0] d;} txn_t;
  typedef struct {logic w; logic [3:0] r; logic [7:0] wd; logic [7:0] di; logic e_wren; logic e_oe; logic e_rv; logic [7:0] e_rd;} vec_t;
  txn_t exp_q[$];
  vec_t vt[7];
  int n_cmp = 0, n_bad = 0, cyc = 0, acc_cnt = 0, n_done = 0;
  logic [7:0] di_smp;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic wait_idle(input string nm);
    int g = 0;
    while ((busy || !bus_cs_n) && g < 2000) begin @(negedge clk); g++; end
    chk(nm, busy, 0);
    repeat (2) @(negedge clk);
  endtask

  // request acceptance feeds the in-order expectation queue
  always @(posedge clk) begin
    cyc <= cyc + 1;
    di_smp <= bus_data_i;
    if (!rst && req_valid && req_ready) begin
      exp_q.push_back({req_write, req_reg, req_wdata});
      acc_cnt <= acc_cnt + 1;
    end
  end

  // bus monitor: protocol rules and completed transactions against the queue
  initial begin
    logic m_prev, m_seen, m_w;
    logic [3:0] m_rs;
    logic [7:0] m_d;
    int m_lo, m_wlo, m_hi;
    txn_t e;
    m_prev = 1; m_seen = 0; m_w = 0; m_rs = 0; m_d = 0; m_lo = 0; m_wlo = 0; m_hi = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        m_prev = 1; m_seen = 0; m_lo = 0; m_wlo = 0;
      end else begin
        chk("wren_inside_cs", !bus_wren_n && bus_cs_n, 0);
        chk("rsp_valid_timing", rsp_valid, !m_prev && bus_cs_n && !m_w);
        if (!bus_cs_n) begin
          if (m_prev) begin
            if (m_seen) chk("cs_gap_min", m_hi >= GAP, 1);
            m_seen = 1; m_rs = bus_rs; m_w = !bus_wren_n; m_d = bus_data_o; m_lo = 0; m_wlo = 0;
          end
          m_lo++;
          m_wlo += int'(!bus_wren_n);
          chk("rs_stable_in_cs", bus_rs, m_rs);
          chk("oe_only_writes", bus_data_oe, m_w);
        end else if (!m_prev) begin
          m_hi = 1;
          n_done++;
          chk("strobe_len", m_lo, T);
          chk("wren_len", m_wlo, m_w ? m_lo : 0);
          chk("hold_rs", bus_rs, m_rs);
          chk("hold_oe", bus_data_oe, m_w);
          if (m_w) chk("hold_data", bus_data_o, m_d);
          else chk("rsp_rdata", rsp_rdata, di_smp);
          if (exp_q.size() == 0) chk("spurious_cycle", 1, 0);
          else begin
            e = exp_q.pop_front();
            chk("order_write", m_w, e.w);
            chk("order_reg", m_rs, e.r);
            if (e.w) chk("order_wdata", m_d, e.d);
          end
        end else m_hi++;
        m_prev = bus_cs_n;
      end
    end
  end

  initial begin
    logic lo, bl;
    int t_acc[5];
    int a0, g, tr, tc, la, acc0, d0, issued;
    vt[0] = '{1'b1, REG_DATA,     8'h41, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00};
    vt[1] = '{1'b0, REG_WADDR_LO, 8'h00, 8'h5A, 1'b1, 1'b0, 1'b1, 8'h5A};
    vt[2] = '{1'b1, REG_MODE,     8'h00, 8'h33, 1'b0, 1'b1, 1'b0, 8'h00};
    vt[3] = '{1'b1, REG_WADDR_HI, 8'hFF, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00};
    vt[4] = '{1'b0, 4'd15,        8'hC3, 8'hA5, 1'b1, 1'b0, 1'b1, 8'hA5};
    vt[5] = '{1'b0, REG_MODE,     8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 8'h00};
    vt[6] = '{1'b0, REG_WADDR_HI, 8'h00, 8'hFF, 1'b1, 1'b0, 1'b1, 8'hFF};
    repeat (3) @(negedge clk);
    chk("rst_cs_n", bus_cs_n, 1);
    chk("rst_wren_n", bus_wren_n, 1);
    chk("rst_rs", bus_rs, 0);
    chk("rst_data_o", bus_data_o, 0);
    chk("rst_oe", bus_data_oe, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rdata", rsp_rdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", req_ready, 1);
    @(posedge clk); #1 rst = 0;
    repeat (2) @(posedge clk);

    for (int v = 0; v < 7; v++) begin
      @(posedge clk); #1;
      req_valid = 1; req_write = vt[v].w; req_reg = vt[v].r; req_wdata = vt[v].wd; bus_data_i = ~vt[v].di;
      @(posedge clk); #1 req_valid = 0;
      for (int k = 0; k <= 2 + S + T + H; k++) begin
        @(negedge clk);
        lo = (k >= 2 + S) && (k <= 1 + S + T);
        chk("tv_cs_n", bus_cs_n, !lo);
        chk("tv_wren_n", bus_wren_n, lo ? vt[v].e_wren : 1'b1);
        chk("tv_busy", busy, k < 2 + S + T + H);
        chk("tv_rsp_valid", rsp_valid, (k == 2 + S + T) ? vt[v].e_rv : 1'b0);
        if (k >= 2 && k <= 2 + S + T) begin
          chk("tv_rs", bus_rs, vt[v].r);
          chk("tv_oe", bus_data_oe, vt[v].e_oe);
          if (vt[v].e_oe) chk("tv_data_o", bus_data_o, vt[v].wd);
        end
        if (k == 2 + S + T && vt[v].e_rv) chk("tv_rdata", rsp_rdata, vt[v].e_rd);
        if (k == 2 + S + T + H) chk("tv_oe_release", bus_data_oe, 0);
        bus_data_i = (k == 1 + S + T) ? vt[v].di : ~vt[v].di;
      end
    end

    wait_idle("idle_5p");
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      req_valid = 1; req_write = i[0]; req_reg = 4'(i + 1); req_wdata = 8'(16 * i + 3);
      a0 = acc_cnt; g = 0;
      do begin @(posedge clk); #1; g++; end while (acc_cnt == a0 && g < 100);
      t_acc[i] = cyc;
    end
    req_valid = 0;
    chk("5p_consecutive", t_acc[4] - t_acc[0], 4);
    chk("5p_ready_full", req_ready, 0);
    g = 0;
    while (!req_ready && g < 200) begin @(negedge clk); g++; end
    chk("5p_ready_rise", req_ready, 1);
    tr = cyc; g = 0;
    while (bus_cs_n && g < 200) begin @(negedge clk); g++; end
    tc = cyc;
    chk("5p_pop_to_cs", tc - tr, S);
    wait_idle("5p_idle");
    chk("5p_all_done", exp_q.size(), 0);

    @(posedge clk); #1 req_valid = 1; req_write = 0; req_reg = REG_WADDR_LO;
    @(posedge clk); #1 req_write = 1; req_reg = REG_WADDR_HI; req_wdata = 8'h11;
    @(posedge clk); #1 req_reg = REG_DATA; req_wdata = 8'h22;
    @(posedge clk); #1 req_valid = 0;
    @(posedge clk);
    @(posedge clk); #2;
    chk("abort_mid_strobe", bus_cs_n, 0);
    rst = 1; #1;
    chk("abort_cs_n", bus_cs_n, 1);
    chk("abort_wren_n", bus_wren_n, 1);
    chk("abort_oe", bus_data_oe, 0);
    chk("abort_busy", busy, 0);
    chk("abort_rsp", rsp_valid, 0);
    chk("abort_ready", req_ready, 1);
    exp_q.delete();
    @(posedge clk); #1 rst = 0;
    repeat (20) begin
      @(negedge clk);
      chk("post_abort_cs_n", bus_cs_n, 1);
      chk("post_abort_rsp", rsp_valid, 0);
      chk("post_abort_busy", busy, 0);
    end

    acc0 = acc_cnt; la = acc_cnt; d0 = n_done; issued = 0;
    for (int c = 0; c < 5000 && acc_cnt - acc0 < NR; c++) begin
      @(posedge clk); #1;
      bus_data_i = 8'($urandom);
      if (acc_cnt != la) begin la = acc_cnt; req_valid = 0; end
      if (!req_valid && issued < NR && $urandom_range(0, 2) != 0) begin
        req_valid = 1; req_write = 1'($urandom); req_reg = 4'($urandom); req_wdata = 8'($urandom);
        issued++;
      end
    end
    req_valid = 0;
    chk("rnd_accepted", acc_cnt - acc0, NR);
    wait_idle("rnd_idle");
    chk("rnd_drained", exp_q.size(), 0);
    chk("rnd_done", n_done - d0, NR);

    @(posedge clk); #1 b_req_valid = 1; b_req_write = 1; b_req_reg = REG_MODE; b_req_wdata = 8'h00;
    @(posedge clk); #1 b_req_wdata = 8'hFF;
    @(posedge clk); #1 b_req_valid = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      bl = (k == 3) || (k == 7);
      chk("b_cs_n", b_cs_n, !bl);
      chk("b_wren_n", b_wren_n, !bl);
      if (bl) begin
        chk("b_rs", b_rs, REG_MODE);
        chk("b_oe", b_oe, 1);
        chk("b_data_o", b_data_o, (k == 3) ? 8'h00 : 8'hFF);
      end
    end
    chk("b_busy_end", b_busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
